// File: rtl/arbiter_types.sv
// arbiter_types: FSM/grant encodings and line geometry shared by the cache arbiter.
package arbiter_types;
  typedef enum logic [1:0] {IDLE, BURST, DONE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;
  localparam int LINE_OFFSET_BITS = 5;
endpackage

// File: rtl/arbiter_line_buffer.sv
// arbiter_line_buffer: one cache line, loaded whole or a beat at a time, read back per beat.
module arbiter_line_buffer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              beat_we,
  input  logic [IW-1:0]     beat_idx,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] rd_data
);
  logic [LINE_W-1:0] line_q, line_d;
  always_comb begin
    line_d = line_q;
    if (load) line_d = load_data;
    else if (beat_we) line_d[beat_idx*BEAT_W +: BEAT_W] = beat_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) line_q <= '0;
    else line_q <= line_d;
  assign line = line_q;
  assign rd_data = line_q[rd_idx*BEAT_W +: BEAT_W];
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one burst memory port between I-cache fills and D-cache fills/writebacks.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CW = $clog2(BEATS);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);
  arb_state_t state_q, state_d;
  arb_grant_t owner_q, owner_d, last_q, last_d;
  logic wr_q, wr_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [BEAT_W-1:0] wdata_q, wdata_d, rd_beat;
  logic [LINE_W-1:0] line;
  logic i_req, d_req, pick_d, grant, load, beat_we;
  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  assign pick_d = d_req & (~i_req | (last_q == GRANT_I));
  assign grant = (state_q == IDLE) & (i_req | d_req);
  assign load = grant & pick_d & d_pmem_write;
  assign beat_we = (state_q == BURST) & mem_resp & ~wr_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    owner_d = owner_q;
    last_d = last_q;
    wr_d = wr_q;
    addr_d = addr_q;
    mem_read_d = 1'b0;
    mem_write_d = 1'b0;
    i_resp_d = 1'b0;
    d_resp_d = 1'b0;
    case (state_q)
      IDLE: if (grant) begin
        state_d = BURST;
        owner_d = pick_d ? GRANT_D : GRANT_I;
        last_d = owner_d;
        wr_d = pick_d & d_pmem_write;
        addr_d = (pick_d ? d_pmem_address : i_pmem_address) & ADDR_MASK;
        cnt_d = '0;
        mem_read_d = ~wr_d;
        mem_write_d = wr_d;
      end
      BURST: begin
        mem_read_d = mem_read_q;
        mem_write_d = mem_write_q;
        if (mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BEATS - 1)) begin
            state_d = DONE;
            mem_read_d = 1'b0;
            mem_write_d = 1'b0;
            i_resp_d = owner_q == GRANT_I;
            d_resp_d = owner_q == GRANT_D;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Write beats are registered one step ahead: the beat for the next counter value.
  assign wdata_d = load ? d_pmem_wdata[BEAT_W-1:0] : rd_beat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      owner_q <= GRANT_I;
      last_q <= GRANT_I;
      wr_q <= 1'b0;
      addr_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      last_q <= last_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_resp_q <= i_resp_d;
      d_resp_q <= d_resp_d;
      wdata_q <= wdata_d;
    end
  arbiter_line_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .IW(CW)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_data(d_pmem_wdata),
    .beat_we(beat_we),
    .beat_idx(cnt_q),
    .beat_data(mem_rdata),
    .rd_idx(cnt_d),
    .line(line),
    .rd_data(rd_beat)
  );
  assign i_pmem_rdata = line;
  assign d_pmem_rdata = line;
  assign i_pmem_resp = i_resp_q;
  assign d_pmem_resp = d_resp_q;
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_address = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed checks of arbitration, burst sequencing and reset behaviour.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_pmem_read = 1'b0;
  logic [31:0] i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic i_pmem_resp;
  logic d_pmem_read = 1'b0;
  logic d_pmem_write = 1'b0;
  logic [31:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic d_pmem_resp;
  logic mem_read, mem_write;
  logic [31:0] mem_address;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata = '0;
  logic mem_resp = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int wait_k = 0;
  int bidx = 0;
  int wcnt = 0;
  logic [BEAT_W-1:0] rbeats [4];
  logic [BEAT_W-1:0] wlog [$];

  cache_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Memory model: wait_k idle cycles before each beat, beats served in order.
  always @(negedge clk) begin
    if (mem_resp) begin
      bidx = bidx + 1;
      wcnt = 0;
    end
    mem_resp = 1'b0;
    if (mem_read || mem_write) begin
      if (wcnt >= wait_k) mem_resp = 1'b1;
      else wcnt = wcnt + 1;
      mem_rdata = rbeats[bidx % 4];
    end else begin
      bidx = 0;
      wcnt = 0;
    end
  end

  always @(posedge clk)
    if (mem_write && mem_resp) wlog.push_back(mem_wdata);

  task automatic wait_resp(input int start, output int cyc, output logic iv, output logic dv);
    bit seen = 0;
    cyc = -1;
    iv = 1'b0;
    dv = 1'b0;
    for (int c = start; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (i_pmem_resp || d_pmem_resp) begin
        seen = 1;
        cyc = c + 1;
        iv = i_pmem_resp;
        dv = d_pmem_resp;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, i_pmem_resp, d_pmem_resp});
    end
    n_checks++;
    if (mem_address !== 32'h0 || mem_wdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mem: addr %h wdata %h expected 0", mem_address, mem_wdata);
    end
    n_checks++;
    if (i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_line: got %h expected 0", i_pmem_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    int cyc;
    logic iv, dv;
    logic [LINE_W-1:0] exp;
    wait_k = 0;
    rbeats[0] = 64'h1111_1111_1111_1111;
    rbeats[1] = 64'h2222_2222_2222_2222;
    rbeats[2] = 64'h3333_3333_3333_3333;
    rbeats[3] = 64'h4444_4444_4444_4444;
    exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    i_pmem_address = 32'h0000_1234;
    i_pmem_read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h0000_1220) begin
      n_fail++;
      $display("FAIL i_read_cmd: rd %b wr %b addr %h expected 1 0 00001220", mem_read, mem_write, mem_address);
    end
    wait_resp(1, cyc, iv, dv);
    i_pmem_read = 1'b0;
    n_checks++;
    if (cyc !== 5) begin
      n_fail++;
      $display("FAIL i_read_latency: got %0d expected 5", cyc);
    end
    n_checks++;
    if (iv !== 1'b1 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL i_read_resp: i %b d %b expected 1 0", iv, dv);
    end
    n_checks++;
    if (i_pmem_rdata !== exp) begin
      n_fail++;
      $display("FAIL i_read_data: got %h expected %h", i_pmem_rdata, exp);
    end
    @(negedge clk);
    n_checks++;
    if (i_pmem_resp !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL i_read_pulse: resp %b mem_read %b expected 0 0", i_pmem_resp, mem_read);
    end
  endtask

  task automatic test_d_write();
    int cyc;
    logic iv, dv;
    logic [LINE_W-1:0] wd;
    logic [BEAT_W-1:0] e;
    wait_k = 2;
    wlog.delete();
    wd = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    d_pmem_wdata = wd;
    d_pmem_address = 32'h8000_0040;
    d_pmem_write = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h8000_0040) begin
      n_fail++;
      $display("FAIL d_write_cmd: wr %b rd %b addr %h expected 1 0 80000040", mem_write, mem_read, mem_address);
    end
    wait_resp(1, cyc, iv, dv);
    d_pmem_write = 1'b0;
    n_checks++;
    if (cyc !== 13 || dv !== 1'b1 || iv !== 1'b0) begin
      n_fail++;
      $display("FAIL d_write_resp: cyc %0d d %b i %b expected 13 1 0", cyc, dv, iv);
    end
    n_checks++;
    if (wlog.size() !== 4) begin
      n_fail++;
      $display("FAIL d_write_beats: got %0d expected 4", wlog.size());
    end
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      e = wd[k*BEAT_W +: BEAT_W];
      n_checks++;
      if (wlog[k] !== e) begin
        n_fail++;
        $display("FAIL d_write_beat%0d: got %h expected %h", k, wlog[k], e);
      end
    end
    @(negedge clk);
    n_checks++;
    if (d_pmem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL d_write_pulse: got %b expected 0", d_pmem_resp);
    end
    wait_k = 0;
  endtask

  task automatic test_contention();
    int cyc;
    logic iv, dv;
    do_reset();
    wait_k = 0;
    i_pmem_address = 32'h0000_0100;
    d_pmem_address = 32'h0000_0200;
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_address !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL cont1_first: addr %h expected 00000200", mem_address);
    end
    wait_resp(1, cyc, iv, dv);
    d_pmem_read = 1'b0;
    n_checks++;
    if (cyc !== 5 || dv !== 1'b1 || iv !== 1'b0) begin
      n_fail++;
      $display("FAIL cont1_d_resp: cyc %0d d %b i %b expected 5 1 0", cyc, dv, iv);
    end
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL cont1_gap: mem_read %b expected 0", mem_read);
    end
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL cont1_second: rd %b addr %h expected 1 00000100", mem_read, mem_address);
    end
    wait_resp(1, cyc, iv, dv);
    i_pmem_read = 1'b0;
    n_checks++;
    if (cyc !== 5 || iv !== 1'b1 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL cont1_i_resp: cyc %0d i %b d %b expected 5 1 0", cyc, iv, dv);
    end
    @(negedge clk);
    d_pmem_address = 32'h0000_0300;
    d_pmem_read = 1'b1;
    wait_resp(0, cyc, iv, dv);
    d_pmem_read = 1'b0;
    n_checks++;
    if (dv !== 1'b1) begin
      n_fail++;
      $display("FAIL d_only_resp: got %b expected 1", dv);
    end
    @(negedge clk);
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_address !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL cont2_first: addr %h expected 00000100", mem_address);
    end
    wait_resp(1, cyc, iv, dv);
    i_pmem_read = 1'b0;
    n_checks++;
    if (iv !== 1'b1 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL cont2_i_resp: i %b d %b expected 1 0", iv, dv);
    end
    wait_resp(0, cyc, iv, dv);
    d_pmem_read = 1'b0;
    n_checks++;
    if (cyc !== 6 || dv !== 1'b1 || iv !== 1'b0) begin
      n_fail++;
      $display("FAIL cont2_d_resp: cyc %0d d %b i %b expected 6 1 0", cyc, dv, iv);
    end
    @(negedge clk);
  endtask

  task automatic test_read_write_both();
    int cyc;
    logic iv, dv;
    wlog.delete();
    d_pmem_address = 32'h0000_0480;
    d_pmem_read = 1'b1;
    d_pmem_write = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_both_cmd: wr %b rd %b expected 1 0", mem_write, mem_read);
    end
    wait_resp(1, cyc, iv, dv);
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    n_checks++;
    if (dv !== 1'b1 || wlog.size() !== 4) begin
      n_fail++;
      $display("FAIL rw_both_done: d %b beats %0d expected 1 4", dv, wlog.size());
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int cyc;
    logic iv, dv;
    int spurious = 0;
    logic [LINE_W-1:0] exp;
    wait_k = 0;
    i_pmem_address = 32'h0000_2000;
    i_pmem_read = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    n_checks++;
    if (mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_drop: mem_read %b expected 0", mem_read);
    end
    repeat (2) begin
      @(negedge clk);
      spurious += int'(i_pmem_resp) + int'(d_pmem_resp);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      spurious += int'(i_pmem_resp) + int'(d_pmem_resp);
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++;
      $display("FAIL async_reset_noresp: got %0d pulses expected 0", spurious);
    end
    rbeats[0] = 64'h5555_5555_5555_5555;
    rbeats[1] = 64'h6666_6666_6666_6666;
    rbeats[2] = 64'h7777_7777_7777_7777;
    rbeats[3] = 64'h8888_8888_8888_8888;
    exp = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    i_pmem_address = 32'h0000_3010;
    i_pmem_read = 1'b1;
    wait_resp(0, cyc, iv, dv);
    i_pmem_read = 1'b0;
    n_checks++;
    if (cyc !== 5 || iv !== 1'b1 || i_pmem_rdata !== exp) begin
      n_fail++;
      $display("FAIL async_reset_restart: cyc %0d i %b data %h expected 5 1 %h", cyc, iv, i_pmem_rdata, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_request();
    int cyc;
    logic iv, dv;
    int extra = 0;
    wait_k = 0;
    i_pmem_address = 32'h0000_4000;
    i_pmem_read = 1'b1;
    repeat (2) @(negedge clk);
    i_pmem_read = 1'b0;
    wait_resp(2, cyc, iv, dv);
    n_checks++;
    if (cyc !== 5 || iv !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_resp: cyc %0d i %b expected 5 1", cyc, iv);
    end
    repeat (3) begin
      @(negedge clk);
      extra += int'(i_pmem_resp);
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL drop_single_pulse: extra %0d expected 0", extra);
    end
  endtask

  initial begin
    rbeats[0] = '0;
    rbeats[1] = '0;
    rbeats[2] = '0;
    rbeats[3] = '0;
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_read_write_both();
    test_async_reset();
    test_drop_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the instruction-cache and data-cache line-fill/writeback ports onto one shared physical-memory port. Each cache sees a full-line request/response interface; the memory side sees a burst of `BEATS` narrow beats. The block sits between the two caches and main memory. It serializes and deserializes lines through an internal line buffer and grants alternately when both caches contend.

## Interface
- `LINE_W`, 256, cache line width in bits
- `BEAT_W`, 64, memory beat width in bits
- `BEATS`, `LINE_W/BEAT_W` (4), beats per burst; derived, not overridden
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `i_pmem_read`  in  1  I-cache line read request, held until `i_pmem_resp`
- `i_pmem_address`  in  32  I-cache line address
- `i_pmem_rdata`  out  LINE_W  filled line, valid while `i_pmem_resp`
- `i_pmem_resp`  out  1  one-cycle completion pulse to I-cache
- `d_pmem_read` / `d_pmem_write`  in  1 each  D-cache line read / writeback request, held until `d_pmem_resp`
- `d_pmem_address`  in  32  D-cache line address
- `d_pmem_wdata`  in  LINE_W  writeback line
- `d_pmem_rdata`  out  LINE_W  filled line, valid while `d_pmem_resp`
- `d_pmem_resp`  out  1  one-cycle completion pulse to D-cache
- `mem_read` / `mem_write`  out  1 each  burst command to memory
- `mem_address`  out  32  line-aligned burst address
- `mem_wdata`  out  BEAT_W  current write beat
- `mem_rdata`  in  BEAT_W  current read beat
- `mem_resp`  in  1  beat accepted/valid

## Operation
- States:
  - IDLE → BURST on any request.
  - BURST → DONE when the beat counter reaches BEATS-1 with `mem_resp` high.
  - DONE → IDLE unconditionally.
- Grant in IDLE:
  - If only one cache requests, it wins.
  - If both request, the winner is the requester not in `last_grant`. `last_grant` resets to I, so D wins the first contention.
- On grant, latch the following:
  - Requester.
  - Op: write if `d_pmem_write`; if D asserts read and write together, write wins.
  - Address with bits [4:0] forced to 0.
  - For writes, `d_pmem_wdata` into the line buffer.
- Write `last_grant`.
- BURST:
  - `mem_read` or `mem_write` is held high and `mem_address` is held constant.
  - On each `mem_resp`, the 2-bit counter increments.
  - Read: the beat is stored into line buffer slice [cnt*BEAT_W +: BEAT_W]. Beat 0 is the low bits.
  - Write: `mem_wdata` = buffer slice cnt.
- DONE:
  - `mem_read`/`mem_write` low.
  - Exactly one of `i_pmem_resp`/`d_pmem_resp` pulses. The matching rdata equals the line buffer; for writes, rdata content is don't-care.
  - Requests are ignored this cycle; requesters deassert the cycle after resp.
- A requester dropping its request mid-burst does not abort the burst. The arbiter completes the burst and still pulses resp.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, cnt 0, `last_grant` = I, line buffer 0.
- Asserting `rst_n` low mid-burst forces IDLE and drops `mem_read`/`mem_write` immediately (asynchronous). No resp is issued.
- Latency:
  - Request sampled at edge N; `mem_read`/`mem_write` high from N+1.
  - A `mem_resp` in the same cycle as the first command cycle counts as beat 0.
  - With one-cycle memory, resp pulses at N+1+BEATS. With k wait cycles per beat, add BEATS*k.
- Back-to-back: the earliest new grant is the cycle after DONE. Minimum gap between bursts is one idle command cycle.
- `i_pmem_rdata`/`d_pmem_rdata` are driven from the line buffer continuously and are only meaningful during resp.

## Structure
- Package `arbiter_types` holds:
  - `arb_state_t` (IDLE, BURST, DONE).
  - `arb_grant_t` (GRANT_I, GRANT_D).
  - `LINE_OFFSET_BITS` = 5.
- One sub-module, `arbiter_line_buffer`:
  - `LINE_W`-wide register.
  - Full-line load, per-beat write at index, per-beat read mux.
- The FSM, counter and grant logic live in `cache_arbiter`.

## Test plan
- I-only read, address 0x0000_1234, memory beats 0x11..,0x22..,0x33..,0x44.. with zero wait → `mem_address`=0x0000_1220; `i_pmem_rdata`={0x44..,0x33..,0x22..,0x11..}; resp 5 cycles after request; `d_pmem_resp` stays 0.
- D writeback of 256'hA..D to 0x8000_0040 with 2 wait cycles per beat → `mem_wdata` presents slices 0..3 in order, each held until its `mem_resp`; single `d_pmem_resp`.
- I and D request in the same cycle from reset → D served first; I served immediately after; a second simultaneous pair → I served first.
- D asserts read and write together → a write burst is performed.
- `rst_n` low after 2 beats of a read → `mem_read` drops asynchronously, no resp; the next request restarts at beat 0.
- Requester drops `i_pmem_read` mid-burst → burst completes, `i_pmem_resp` still pulses once.
